// File: rtl/noc_flit_pkg.sv
// noc_flit_pkg
//   Shared definitions for the flit routing slice.
//   - FLIT_W      : flit width in bits.
//   - FLIT_HEAD / FLIT_TAIL : flit-type codes carried in the two MSBs.
//                  Codes 01 and 10 are body flits.
//   - st_t        : routing state (IDLE, LOCK_A, LOCK_B).
//   - flitType()  : extracts the type field from a flit.
package noc_flit_pkg;

    localparam int FLIT_W = 32;

    localparam logic [1:0] FLIT_HEAD = 2'b00;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } st_t;

    function automatic logic [1:0] flitType(input logic [FLIT_W-1:0] flit);
        return flit[FLIT_W-1 -: 2];
    endfunction

endpackage

// File: rtl/flit_out_slot.sv
// flit_out_slot
//   One registered output slot with a valid/ready handshake.
//   Ports:
//     clk, rstn      : clock, synchronous active-low reset
//     Load_i         : load Data_i into the slot on this edge
//     Data_i [32]    : flit to load
//     Ready_i        : consumer accepts the held flit on this edge
//     Valid_o        : slot holds a flit (registered)
//     Data_o [32]    : held flit (registered, changes only on a load)
//     Free_o         : slot can take a new flit on this edge
//
//   Handshake: a flit is transferred on every rising edge where Valid_o
//   and Ready_i are both 1. While Valid_o = 1 and Ready_i = 0, Valid_o and
//   Data_o stay stable. A load on the same edge as a transfer replaces the
//   departing flit, so Valid_o stays 1 and one flit per cycle is sustained.
module flit_out_slot
    import noc_flit_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              Load_i,
    input  logic [FLIT_W-1:0] Data_i,
    input  logic              Ready_i,
    output logic              Valid_o,
    output logic [FLIT_W-1:0] Data_o,
    output logic              Free_o
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            Valid_o <= 1'b0;
            Data_o  <= '0;
        end else if (Load_i) begin
            Valid_o <= 1'b1;
            Data_o  <= Data_i;
        end else if (Ready_i) begin
            Valid_o <= 1'b0;
        end
    end

    // Ready_i only reaches the free flag, never the registered outputs.
    assign Free_o = ~Valid_o | Ready_i;

endmodule

// File: rtl/flit_route_1x2.sv
// flit_route_1x2
//   Wormhole demultiplexer on the read side of a first-word-fall-through
//   FIFO. The head flit picks port A or B (bit ROUTE_BIT, 0 = A, 1 = B) and
//   the port stays locked until the tail flit has been forwarded.
//   Optional feature macro: FLIT_ROUTE_ERRCHK_EN (sticky orphan-flit flag).
//   Ports:
//     clk, rstn        : clock, synchronous active-low reset
//     FifoEmpty_i      : FIFO empty
//     FifoRdData_i[32] : FIFO head word, valid when FifoEmpty_i = 0
//     FifoRd_o         : pop strobe (combinational)
//     ValidA_o/DataA_o : port A slot (registered), ReadyA_i consumer accept
//     ValidB_o/DataB_o : port B slot (registered), ReadyB_i consumer accept
//     Err_o            : sticky orphan-flit flag (registered; 0 when the
//                        macro is undefined)
//     StDbg_o          : current routing state, for observation
module flit_route_1x2
    import noc_flit_pkg::*;
#(
    parameter int ROUTE_BIT = 29
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              FifoEmpty_i,
    input  logic [FLIT_W-1:0] FifoRdData_i,
    output logic              FifoRd_o,
    output logic              ValidA_o,
    output logic [FLIT_W-1:0] DataA_o,
    input  logic              ReadyA_i,
    output logic              ValidB_o,
    output logic [FLIT_W-1:0] DataB_o,
    input  logic              ReadyB_i,
    output logic              Err_o,
    output logic [1:0]        StDbg_o
);

    st_t  St;
    st_t  stNxt;
    logic isHead;
    logic isTail;
    logic discard;
    logic tgtB;
    logic tgtFree;
    logic loadA;
    logic loadB;
    logic freeA;
    logic freeB;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            St <= IDLE;
        end else begin
            St <= stNxt;
        end
    end

    always_comb begin
        isHead  = (flitType(FifoRdData_i) == FLIT_HEAD);
        isTail  = (flitType(FifoRdData_i) == FLIT_TAIL);
        // A non-head flit seen while no packet is open has no port to go to.
        discard = (St == IDLE) && !isHead;

        tgtB = 1'b0;
        case (St)
            IDLE:    tgtB = FifoRdData_i[ROUTE_BIT];
            LOCK_A:  tgtB = 1'b0;
            LOCK_B:  tgtB = 1'b1;
            default: tgtB = 1'b0;
        endcase

        tgtFree  = tgtB ? freeB : freeA;
        FifoRd_o = ~FifoEmpty_i & (discard | tgtFree);

        // Heads arriving mid-lock are not re-examined: they travel as body.
        loadA = FifoRd_o & ~discard & ~tgtB;
        loadB = FifoRd_o & ~discard &  tgtB;

        stNxt = St;
        if (FifoRd_o) begin
            case (St)
                IDLE:    if (isHead) stNxt = tgtB ? LOCK_B : LOCK_A;
                LOCK_A,
                LOCK_B:  if (isTail) stNxt = IDLE;
                default: stNxt = IDLE;
            endcase
        end
    end

    flit_out_slot u_slotA (
        .clk     (clk),
        .rstn    (rstn),
        .Load_i  (loadA),
        .Data_i  (FifoRdData_i),
        .Ready_i (ReadyA_i),
        .Valid_o (ValidA_o),
        .Data_o  (DataA_o),
        .Free_o  (freeA)
    );

    flit_out_slot u_slotB (
        .clk     (clk),
        .rstn    (rstn),
        .Load_i  (loadB),
        .Data_i  (FifoRdData_i),
        .Ready_i (ReadyB_i),
        .Valid_o (ValidB_o),
        .Data_o  (DataB_o),
        .Free_o  (freeB)
    );

`ifdef FLIT_ROUTE_ERRCHK_EN
    logic errQ;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            errQ <= 1'b0;
        end else if (FifoRd_o && discard) begin
            errQ <= 1'b1;
        end
    end

    assign Err_o = errQ;
`else
    assign Err_o = 1'b0;
`endif

    assign StDbg_o = St;

endmodule

// File: tb/tb_flit_route_1x2.sv
// tb_flit_route_1x2
//   Directed bench for flit_route_1x2. A queue stands in for the FIFO; a
//   packet-level model turns each pushed word into an expected per-port
//   stream, and a compare process checks every handshake against it.
module tb_flit_route_1x2;
    import noc_flit_pkg::*;

`ifdef FLIT_ROUTE_ERRCHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rstn;
    logic        FifoEmpty_i;
    logic [31:0] FifoRdData_i;
    logic        FifoRd_o;
    logic        ValidA_o;
    logic [31:0] DataA_o;
    logic        ReadyA_i;
    logic        ValidB_o;
    logic [31:0] DataB_o;
    logic        ReadyB_i;
    logic        Err_o;
    logic [1:0]  StDbg_o;

    always #5 clk = ~clk;

    flit_route_1x2 #(.ROUTE_BIT(29)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .FifoEmpty_i  (FifoEmpty_i),
        .FifoRdData_i (FifoRdData_i),
        .FifoRd_o     (FifoRd_o),
        .ValidA_o     (ValidA_o),
        .DataA_o      (DataA_o),
        .ReadyA_i     (ReadyA_i),
        .ValidB_o     (ValidB_o),
        .DataB_o      (DataB_o),
        .ReadyB_i     (ReadyB_i),
        .Err_o        (Err_o),
        .StDbg_o      (StDbg_o)
    );

    // ---------------- bookkeeping ----------------
    int          tests_run = 0;
    int          fails     = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];
    bit          exp_err   = 1'b0;
    int          mdl_lock  = 0;   // 0 none, 1 port A, 2 port B
    bit          hold_empty = 1'b0;
    bit          pop_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Packet-level routing model: decides where each word must end up.
    task automatic push(input logic [31:0] w);
        logic [1:0] ty;
        ty = w[31:30];
        fifo_q.push_back(w);
        if (mdl_lock == 0) begin
            if (ty == 2'b00) begin
                mdl_lock = w[29] ? 2 : 1;
                if (mdl_lock == 1) exp_a_q.push_back(w);
                else               exp_b_q.push_back(w);
            end else begin
                if (ERR_EN) exp_err = 1'b1;
            end
        end else begin
            if (mdl_lock == 1) exp_a_q.push_back(w);
            else               exp_b_q.push_back(w);
            if (ty == 2'b11) mdl_lock = 0;
        end
    endtask

    task automatic flush_model();
        fifo_q.delete();
        exp_a_q.delete();
        exp_b_q.delete();
        mdl_lock = 0;
        exp_err  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_a_q.size() != 0 || exp_b_q.size() != 0 ||
                ValidA_o || ValidB_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(n < 200), 32'd1);
    endtask

    // ---------------- FIFO driver ----------------
    initial begin
        FifoEmpty_i  = 1'b1;
        FifoRdData_i = '0;
        forever begin
            @(negedge clk);
            pop_s = FifoRd_o & rstn;
            @(posedge clk);
            #1;
            if (pop_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
            #1;
            FifoEmpty_i  = hold_empty | (fifo_q.size() == 0);
            FifoRdData_i = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
        end
    end

    // ---------------- scoreboard / compare ----------------
    bit          stall_a = 1'b0;
    bit          stall_b = 1'b0;
    logic [31:0] stall_da;
    logic [31:0] stall_db;

    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (stall_a) begin
                    check("a_stall_valid", 32'(ValidA_o), 32'd1);
                    check("a_stall_data", DataA_o, stall_da);
                end
                if (stall_b) begin
                    check("b_stall_valid", 32'(ValidB_o), 32'd1);
                    check("b_stall_data", DataB_o, stall_db);
                end
                if (ValidA_o && ReadyA_i) begin
                    if (exp_a_q.size() == 0) begin
                        tests_run++;
                        fails++;
                        $display("FAIL a_unexpected: got 0x%08h, expected no flit", DataA_o);
                    end else begin
                        check("a_data", DataA_o, exp_a_q.pop_front());
                    end
                end
                if (ValidB_o && ReadyB_i) begin
                    if (exp_b_q.size() == 0) begin
                        tests_run++;
                        fails++;
                        $display("FAIL b_unexpected: got 0x%08h, expected no flit", DataB_o);
                    end else begin
                        check("b_data", DataB_o, exp_b_q.pop_front());
                    end
                end
                if (FifoEmpty_i) check("rd_when_empty", 32'(FifoRd_o), 32'd0);
                if (!exp_err)    check("err_low", 32'(Err_o), 32'd0);
                stall_a  = ValidA_o && !ReadyA_i;
                stall_b  = ValidB_o && !ReadyB_i;
                stall_da = DataA_o;
                stall_db = DataB_o;
            end else begin
                stall_a = 1'b0;
                stall_b = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        rstn     = 1'b0;
        ReadyA_i = 1'b1;
        ReadyB_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_a", 32'(ValidA_o), 32'd0);
        check("rst_valid_b", 32'(ValidB_o), 32'd0);
        check("rst_data_a", DataA_o, 32'h0);
        check("rst_data_b", DataB_o, 32'h0);
        check("rst_err", 32'(Err_o), 32'd0);
        check("rst_state", 32'(StDbg_o), 32'(IDLE));
        check("rst_rd", 32'(FifoRd_o), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // 3-flit packet to A
        @(posedge clk); #1;
        push(32'h00000001); push(32'h40000002); push(32'hC0000003);
        @(negedge clk);
        check("t1_lat_valid", 32'(ValidA_o), 32'd0);
        @(negedge clk);
        check("t1_valid1", 32'(ValidA_o), 32'd1);
        check("t1_data1", DataA_o, 32'h00000001);
        check("t1_lock", 32'(StDbg_o), 32'(LOCK_A));
        @(negedge clk);
        check("t1_data2", DataA_o, 32'h40000002);
        check("t1_b_idle", 32'(ValidB_o), 32'd0);
        @(negedge clk);
        check("t1_data3", DataA_o, 32'hC0000003);
        check("t1_idle", 32'(StDbg_o), 32'(IDLE));
        @(negedge clk);
        check("t1_drain", 32'(ValidA_o), 32'd0);
        check("t1_b_never", 32'(ValidB_o), 32'd0);
        wait_idle("t1");

        // Back-to-back packets to alternate ports
        @(posedge clk); #1;
        push(32'h20000010); push(32'hC0000011); push(32'h00000020); push(32'hC0000021);
        @(negedge clk);
        @(negedge clk);
        check("t2_b_head", DataB_o, 32'h20000010);
        check("t2_b_valid", 32'(ValidB_o), 32'd1);
        @(negedge clk);
        check("t2_b_tail", DataB_o, 32'hC0000011);
        @(negedge clk);
        check("t2_a_head", DataA_o, 32'h00000020);
        check("t2_a_valid", 32'(ValidA_o), 32'd1);
        check("t2_b_drained", 32'(ValidB_o), 32'd0);
        @(negedge clk);
        check("t2_a_tail", DataA_o, 32'hC0000021);
        wait_idle("t2");

        // Backpressure on port A
        @(posedge clk); #1;
        push(32'h00000100); push(32'h40000101); push(32'h80000102);
        push(32'h40000103); push(32'hC0000104);
        @(negedge clk);
        @(negedge clk);
        check("t3_head", DataA_o, 32'h00000100);
        @(posedge clk); #1;
        ReadyA_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall_rd", 32'(FifoRd_o), 32'd0);
            check("t3_stall_data", DataA_o, 32'h40000101);
        end
        @(posedge clk); #1;
        ReadyA_i = 1'b1;
        @(negedge clk);
        check("t3_resume_rd", 32'(FifoRd_o), 32'd1);
        @(negedge clk);
        check("t3_resume_data", DataA_o, 32'h80000102);
        check("t3_resume_valid", 32'(ValidA_o), 32'd1);
        @(negedge clk);
        check("t3_next_data", DataA_o, 32'h40000103);
        wait_idle("t3");

        // FIFO underrun inside a packet to B
        @(posedge clk); #1;
        push(32'h20000200); push(32'h40000201);
        @(posedge clk); #1;
        @(posedge clk); #1;
        hold_empty = 1'b1;
        push(32'h80000202); push(32'hC0000203);
        @(negedge clk);
        check("t4_empty_rd", 32'(FifoRd_o), 32'd0);
        check("t4_lock_held", 32'(StDbg_o), 32'(LOCK_B));
        @(negedge clk);
        check("t4_lock_held2", 32'(StDbg_o), 32'(LOCK_B));
        check("t4_b_drained", 32'(ValidB_o), 32'd0);
        @(posedge clk); #1;
        hold_empty = 1'b0;
        @(negedge clk);
        check("t4_resume_rd", 32'(FifoRd_o), 32'd1);
        @(negedge clk);
        check("t4_body_b", DataB_o, 32'h80000202);
        check("t4_a_unused", 32'(ValidA_o), 32'd0);
        wait_idle("t4");

        // Orphan flit in IDLE
        @(posedge clk); #1;
        push(32'h40000005);
        @(negedge clk);
        check("t5_discard_rd", 32'(FifoRd_o), 32'd1);
        @(negedge clk);
        check("t5_popped", fifo_q.size(), 32'd0);
        check("t5_valid_a", 32'(ValidA_o), 32'd0);
        check("t5_valid_b", 32'(ValidB_o), 32'd0);
        check("t5_err", 32'(Err_o), 32'(ERR_EN));
        check("t5_idle", 32'(StDbg_o), 32'(IDLE));
        @(negedge clk);
        check("t5_err_sticky", 32'(Err_o), 32'(ERR_EN));

        // Reset mid-packet
        @(posedge clk); #1;
        push(32'h00000300); push(32'h40000301); push(32'h40000302);
        @(posedge clk); #1;
        check("t6_head_fwd", DataA_o, 32'h00000300);
        rstn = 1'b0;
        @(posedge clk); #1;
        flush_model();
        @(negedge clk);
        check("t6_rst_valid_a", 32'(ValidA_o), 32'd0);
        check("t6_rst_valid_b", 32'(ValidB_o), 32'd0);
        check("t6_rst_state", 32'(StDbg_o), 32'(IDLE));
        check("t6_rst_err", 32'(Err_o), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        push(32'h20000400); push(32'hC0000401);
        @(negedge clk);
        @(negedge clk);
        check("t6_fresh_head", DataB_o, 32'h20000400);
        check("t6_fresh_lock", 32'(StDbg_o), 32'(LOCK_B));
        check("t6_a_quiet", 32'(ValidA_o), 32'd0);
        @(negedge clk);
        check("t6_fresh_tail", DataB_o, 32'hC0000401);
        wait_idle("t6");

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/flit_route_1x2.md
# flit_route_1x2

Wormhole demultiplexer on the read side of a router input FIFO. It pops 32-bit flits from a first-word-fall-through FIFO and routes each packet, from head flit to tail flit, to one of two output ports (A or B). The port is chosen from the head flit and held until the tail flit has been forwarded. Each output port has one registered slot with a valid/ready handshake and sustains one flit per cycle.

## Interface
- `ROUTE_BIT`, default 29: head-flit bit that selects the port; 0 → A, 1 → B.
- `clk`  in  1: clock; all state updates on its rising edge.
- `rstn`  in  1: reset, synchronous, active-low.
- `FifoEmpty_i`  in  1: FIFO empty.
- `FifoRdData_i`  in  32: FIFO head word; valid whenever `FifoEmpty_i` = 0.
- `FifoRd_o`  out  1: pop strobe, combinational.
- `ValidA_o`  out  1: port A holds a flit (registered).
- `DataA_o`  out  32: port A flit (registered).
- `ReadyA_i`  in  1: port A consumer accepts.
- `ValidB_o`  out  1: port B holds a flit (registered).
- `DataB_o`  out  32: port B flit (registered).
- `ReadyB_i`  in  1: port B consumer accepts.
- `Err_o`  out  1: sticky orphan-flit flag (registered).

## Operation
- Flit type is bits [31:30]:
  - 00: head
  - 01, 10: body
  - 11: tail
  - Every packet is at least two flits long.
- State machine `St`, with states IDLE, LOCK_A and LOCK_B.
- Target port `Tgt`:
  - In IDLE with a head flit at the FIFO: `FifoRdData_i[ROUTE_BIT]`.
  - In LOCK_A: A. In LOCK_B: B.
- Port slot X is free when `~ValidX_o | ReadyX_i`.
- `FifoRd_o = ~FifoEmpty_i & (discard | slot[Tgt] free)`.
- `discard`: state is IDLE and the FIFO head is not a head flit (orphan flit).
- Transitions on a pop:
  - IDLE, head flit: go to LOCK_A or LOCK_B according to `Tgt`.
  - LOCK_x, tail flit: go to IDLE.
  - Otherwise: stay.
- Port register X on each edge:
  - If a non-discard pop targets X: `ValidX_o` ← 1 and `DataX_o` ← `FifoRdData_i`.
  - Else if `ReadyX_i`: `ValidX_o` ← 0.
  - `DataX_o` changes only on a load.
- While the output is stalled, `DataX_o` and `ValidX_o` stay stable.
- The port not locked by the current packet is never loaded, whatever its ready level.
- A body or tail flit is never routed in IDLE.
- Head-flit handling in LOCK_x:
  - A head flit arriving in LOCK_x is forwarded as body to the locked port.
  - Packets are not re-validated mid-lock.

## Timing
- Reset values:
  - `St` = IDLE.
  - `ValidA_o` = `ValidB_o` = 0.
  - `DataA_o` = `DataB_o` = 0.
  - `Err_o` = 0.
  - `FifoRd_o` = 0 while the FIFO is empty.
- Reset asserted mid-packet: the lock is dropped and any held flits are lost. This is legal only while the upstream is also in reset.
- Latency: a flit popped at edge n is visible on `DataX_o`/`ValidX_o` after edge n.
- Throughput: one flit per cycle per active packet when `ReadyX_i` is held at 1.
- Handshake:
  - The consumer samples a flit on an edge where `ValidX_o` and `ReadyX_i` are both 1.
  - A load and a drain in the same cycle leave `ValidX_o` = 1 with the new data.
- Back-to-back packets: a tail popped at edge n and the next head popped at edge n+1 is legal, including when the next packet goes to the other port.
- FIFO empty mid-packet: no pop, state is held, and the output drains normally.
- `ReadyX_i` has no combinational path to `ValidX_o` or `DataX_o`. It reaches `FifoRd_o` combinationally only.

## Configuration
- Macro `FLIT_ROUTE_ERRCHK_EN`.
- Defined:
  - An orphan flit in IDLE is popped and discarded; no port is loaded.
  - `Err_o` ← 1 on that edge and stays 1 until reset.
- Undefined:
  - An orphan flit in IDLE is popped and discarded.
  - `Err_o` is tied to 0 and no checking logic is generated.

## Structure
- Shared package `noc_flit_pkg`:
  - Flit width of 32.
  - Flit-type constants: FLIT_HEAD=2'b00, FLIT_TAIL=2'b11.
  - The `St` state enumeration.
- Sub-module `flit_out_slot`: one output register per port, instantiated twice.
  - Ports: `clk`, `rstn`, `Load_i`, `Data_i`, `Ready_i`, `Valid_o`, `Data_o`, `Free_o`.
- Top level contains the state machine, the target mux, the pop logic and the error flag.

## Test plan
- 3-flit packet to A:
  - Stimulus: FIFO holds 0x00000001, 0x40000002, 0xC0000003; `ReadyA_i` = 1.
  - Required: A outputs the three words on three consecutive cycles, starting 1 cycle after the first pop; `ValidB_o` stays 0; state returns to IDLE.
- Back-to-back to alternate ports:
  - Stimulus: head 0x20000010 (bit 29 = 1) plus tail 0xC0000011, immediately followed by head 0x00000020 plus tail 0xC0000021.
  - Required: B receives 0x20000010 and 0xC0000011; A receives 0x00000020 and 0xC0000021; no bubble between packets.
- Backpressure:
  - Stimulus: during a packet to A, `ReadyA_i` = 0 for 3 cycles.
  - Required: `FifoRd_o` = 0 after the slot fills; `DataA_o` is held stable; streaming resumes the cycle `ReadyA_i` rises, with no loss or duplication.
- FIFO underrun:
  - Stimulus: `FifoEmpty_i` = 1 for 2 cycles between body flits.
  - Required: lock is held; the following flits still go to the same port.
- Orphan flit:
  - Stimulus: IDLE, FIFO head 0x40000005.
  - Required: popped with no port valid; `Err_o` = 1 with the macro, 0 without.
- Reset mid-packet:
  - Stimulus: assert `rstn` = 0 after the head flit has been forwarded.
  - Required: next edge gives IDLE with both valids at 0; the next head flit is routed fresh.
